// File: rtl/matrix_display_seq_if.sv
// Matrix memory read port between matrix_display_seq (master) and the
// matrix memory (slave). Read data is expected one slow_clk edge after the
// registered rd_en/rd_addr pair is presented.
interface matrix_display_seq_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/matrix_display_seq.sv
// matrix_display_seq: walks a ROWS x COLS matrix held in memory one element
// at a time and holds each element on the display outputs for DWELL ticks.
// Optional column-major traversal is enabled by defining the macro
// MATRIX_DISPLAY_SEQ_TRANSPOSE_EN, which adds the transpose input.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; display outputs keep their last values
// ST_FETCH | read strobe issued last tick, capture rd_data this tick
// ST_SHOW  | element on display, dwell countdown running (hold freezes it)
module matrix_display_seq #(
  parameter int ROWS   = 2,
  parameter int COLS   = 2,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DWELL  = 1,
  localparam int ROW_W = ($clog2(ROWS) > 0) ? $clog2(ROWS) : 1,
  localparam int COL_W = ($clog2(COLS) > 0) ? $clog2(COLS) : 1,
  localparam int CNT_W = ($clog2(DWELL) > 0) ? $clog2(DWELL) : 1
) (
  input  logic                 slow_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode_loop,
  input  logic                 stop,
  input  logic                 hold,
  input  logic [ADDR_W-1:0]    base_addr,
`ifdef MATRIX_DISPLAY_SEQ_TRANSPOSE_EN
  input  logic                 transpose,
`endif
  matrix_display_seq_if.master mem,
  output logic [DATA_W-1:0]    value,
  output logic                 value_valid,
  output logic [ROW_W-1:0]     row_idx,
  output logic [COL_W-1:0]     col_idx,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              loop_q, loop_d;
  logic              col_major;

  logic              rd_en_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic [DATA_W-1:0] value_d;
  logic              value_valid_d;
  logic [ROW_W-1:0]  row_idx_d;
  logic [COL_W-1:0]  col_idx_d;
  logic              busy_d;
  logic              done_d;

  logic              row_last, col_last, elem_last;
  logic [ROW_W-1:0]  adv_row;
  logic [COL_W-1:0]  adv_col;

`ifdef MATRIX_DISPLAY_SEQ_TRANSPOSE_EN
  logic trn_q, trn_d;
  assign col_major = trn_q;
`else
  assign col_major = 1'b0;
`endif

  // Row-major address of (r, c); the sum wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] elem_addr(
    input logic [ADDR_W-1:0] b,
    input logic [ROW_W-1:0]  r,
    input logic [COL_W-1:0]  c
  );
    return b + ADDR_W'(int'(r) * COLS) + ADDR_W'(int'(c));
  endfunction

  // Successor coordinates in the selected traversal order (only used when
  // the current element is not the last one, so no wrap past the end).
  always_comb begin
    row_last  = (row_q == ROW_W'(ROWS - 1));
    col_last  = (col_q == COL_W'(COLS - 1));
    elem_last = row_last && col_last;
    adv_row   = row_q;
    adv_col   = col_q;
    if (col_major) begin
      if (row_last) begin
        adv_row = '0;
        adv_col = col_q + 1'b1;
      end else begin
        adv_row = row_q + 1'b1;
      end
    end else begin
      if (col_last) begin
        adv_col = '0;
        adv_row = row_q + 1'b1;
      end else begin
        adv_col = col_q + 1'b1;
      end
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    cnt_d         = cnt_q;
    base_d        = base_q;
    loop_d        = loop_q;
`ifdef MATRIX_DISPLAY_SEQ_TRANSPOSE_EN
    trn_d         = trn_q;
`endif
    rd_en_d       = 1'b0;
    rd_addr_d     = mem.rd_addr;
    value_d       = value;
    value_valid_d = 1'b0;
    row_idx_d     = row_idx;
    col_idx_d     = col_idx;
    busy_d        = busy;
    done_d        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d    = base_addr;
          loop_d    = mode_loop;
`ifdef MATRIX_DISPLAY_SEQ_TRANSPOSE_EN
          trn_d     = transpose;
`endif
          row_d     = '0;
          col_d     = '0;
          rd_addr_d = base_addr;
          rd_en_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        value_d       = mem.rd_data;
        value_valid_d = 1'b1;
        row_idx_d     = row_q;
        col_idx_d     = col_q;
        cnt_d         = CNT_W'(DWELL - 1);
        state_d       = ST_SHOW;
      end
      ST_SHOW: begin
        if (!hold) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (loop_q && stop) begin
            // stop ends loop mode after the current element, last or not
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else if (!elem_last) begin
            row_d     = adv_row;
            col_d     = adv_col;
            rd_addr_d = elem_addr(base_q, adv_row, adv_col);
            rd_en_d   = 1'b1;
            state_d   = ST_FETCH;
          end else if (loop_q) begin
            done_d    = 1'b1;
            row_d     = '0;
            col_d     = '0;
            rd_addr_d = base_q;
            rd_en_d   = 1'b1;
            state_d   = ST_FETCH;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, index, counter and registered-output update; reset aborts a pass.
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      base_q      <= '0;
      loop_q      <= 1'b0;
`ifdef MATRIX_DISPLAY_SEQ_TRANSPOSE_EN
      trn_q       <= 1'b0;
`endif
      mem.rd_en   <= 1'b0;
      mem.rd_addr <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      row_idx     <= '0;
      col_idx     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      loop_q      <= loop_d;
`ifdef MATRIX_DISPLAY_SEQ_TRANSPOSE_EN
      trn_q       <= trn_d;
`endif
      mem.rd_en   <= rd_en_d;
      mem.rd_addr <= rd_addr_d;
      value       <= value_d;
      value_valid <= value_valid_d;
      row_idx     <= row_idx_d;
      col_idx     <= col_idx_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_matrix_display_seq.sv
// Bench for matrix_display_seq: a 2x2 DWELL=1 instance driven from a
// per-tick vector table, plus a 2x2 DWELL=3 instance for hold timing.
module tb_matrix_display_seq;

  logic       slow_clk;
  logic       rst;

  logic       start_a, loop_a, stop_a, hold_a;
  logic [5:0] base_a;
  logic [7:0] value_a;
  logic       vv_a, busy_a, done_a;
  logic [0:0] row_a, col_a;

  logic       start_b, hold_b;
  logic [7:0] value_b;
  logic       vv_b, busy_b, done_b;
  logic [0:0] row_b, col_b;

`ifdef MATRIX_DISPLAY_SEQ_TRANSPOSE_EN
  logic       transpose_a;
  logic       transpose_b;
`endif

  logic [7:0] mem [64];

  int checks   = 0;
  int failures = 0;

  matrix_display_seq_if #(.DATA_W(8), .ADDR_W(6)) mif_a ();
  matrix_display_seq_if #(.DATA_W(8), .ADDR_W(6)) mif_b ();

  // Asynchronous-read memory; 0xEE outside a strobe exposes mistimed captures.
  assign mif_a.rd_data = mif_a.rd_en ? mem[mif_a.rd_addr] : 8'hEE;
  assign mif_b.rd_data = mif_b.rd_en ? mem[mif_b.rd_addr] : 8'hEE;

  matrix_display_seq #(
    .ROWS(2), .COLS(2), .DATA_W(8), .ADDR_W(6), .DWELL(1)
  ) u_a (
    .slow_clk    (slow_clk),
    .rst         (rst),
    .start       (start_a),
    .mode_loop   (loop_a),
    .stop        (stop_a),
    .hold        (hold_a),
    .base_addr   (base_a),
`ifdef MATRIX_DISPLAY_SEQ_TRANSPOSE_EN
    .transpose   (transpose_a),
`endif
    .mem         (mif_a),
    .value       (value_a),
    .value_valid (vv_a),
    .row_idx     (row_a),
    .col_idx     (col_a),
    .busy        (busy_a),
    .done        (done_a)
  );

  matrix_display_seq #(
    .ROWS(2), .COLS(2), .DATA_W(8), .ADDR_W(6), .DWELL(3)
  ) u_b (
    .slow_clk    (slow_clk),
    .rst         (rst),
    .start       (start_b),
    .mode_loop   (1'b0),
    .stop        (1'b0),
    .hold        (hold_b),
    .base_addr   (6'd0),
`ifdef MATRIX_DISPLAY_SEQ_TRANSPOSE_EN
    .transpose   (transpose_b),
`endif
    .mem         (mif_b),
    .value       (value_b),
    .value_valid (vv_b),
    .row_idx     (row_b),
    .col_idx     (col_b),
    .busy        (busy_b),
    .done        (done_b)
  );

  initial slow_clk = 1'b0;
  always #5 slow_clk = ~slow_clk;

  typedef struct {
    logic       start, lp, sp, hd;
    logic [5:0] base;
    logic       e_rd_en;
    logic [5:0] e_addr;
    logic       e_vv;
    logic [7:0] e_val;
    logic       e_row, e_col, e_busy, e_done;
  } vec_t;

  vec_t vecs [32];

  function automatic vec_t mk(input int st, input int lp, input int sp, input int hd,
                              input int ba, input int er, input int ea, input int ev,
                              input int eval, input int erow, input int ecol,
                              input int ebusy, input int edone);
    vec_t v;
    v.start   = 1'(st);
    v.lp      = 1'(lp);
    v.sp      = 1'(sp);
    v.hd      = 1'(hd);
    v.base    = 6'(ba);
    v.e_rd_en = 1'(er);
    v.e_addr  = 6'(ea);
    v.e_vv    = 1'(ev);
    v.e_val   = 8'(eval);
    v.e_row   = 1'(erow);
    v.e_col   = 1'(ecol);
    v.e_busy  = 1'(ebusy);
    v.e_done  = 1'(edone);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge slow_clk);
    #1;
  endtask

  task automatic wait_vv(input bit sel_b, input logic [7:0] want, input string nm);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (sel_b ? (vv_b && value_b == want) : (vv_a && value_a == want)) found = 1'b1;
    end
    chk(nm, 32'(found), 32'd1);
  endtask

  task automatic count_rd_b(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!mif_b.rd_en && n < 30);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_rd_en"},   32'(mif_a.rd_en),   32'd0);
    chk({tag, "_rd_addr"}, 32'(mif_a.rd_addr), 32'd0);
    chk({tag, "_value"},   32'(value_a),       32'd0);
    chk({tag, "_vv"},      32'(vv_a),          32'd0);
    chk({tag, "_row"},     32'(row_a),         32'd0);
    chk({tag, "_col"},     32'(col_a),         32'd0);
    chk({tag, "_busy"},    32'(busy_a),        32'd0);
    chk({tag, "_done"},    32'(done_a),        32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  bad;
    bit  found;
`ifdef MATRIX_DISPLAY_SEQ_TRANSPOSE_EN
    logic [7:0] tv [4];
    logic       tr [4];
    logic       tc [4];
`endif

    // start,loop,stop,hold,base | rd_en,addr,vv,value,row,col,busy,done
    vecs[0]  = mk(1,0,0,0, 0,  1, 0,0, 0,0,0,1,0);
    vecs[1]  = mk(0,0,0,0, 0,  0, 0,1,11,0,0,1,0);
    vecs[2]  = mk(0,0,0,0, 0,  1, 1,0,11,0,0,1,0);
    vecs[3]  = mk(0,0,0,0, 0,  0, 1,1,22,0,1,1,0);
    vecs[4]  = mk(0,0,0,0, 0,  1, 2,0,22,0,1,1,0);
    vecs[5]  = mk(0,0,0,0, 0,  0, 2,1,33,1,0,1,0);
    vecs[6]  = mk(0,0,0,0, 0,  1, 3,0,33,1,0,1,0);
    vecs[7]  = mk(1,0,0,0, 0,  0, 3,1,44,1,1,1,0);
    vecs[8]  = mk(1,0,0,0, 0,  0, 3,0,44,1,1,0,1);
    vecs[9]  = mk(1,0,0,0,62,  1,62,0,44,1,1,1,0);
    vecs[10] = mk(0,0,0,0, 0,  0,62,1,66,0,0,1,0);
    vecs[11] = mk(0,0,0,0, 0,  1,63,0,66,0,0,1,0);
    vecs[12] = mk(0,0,0,0, 0,  0,63,1,77,0,1,1,0);
    vecs[13] = mk(0,0,0,0, 0,  1, 0,0,77,0,1,1,0);
    vecs[14] = mk(0,0,0,0, 0,  0, 0,1,11,1,0,1,0);
    vecs[15] = mk(0,0,0,0, 0,  1, 1,0,11,1,0,1,0);
    vecs[16] = mk(0,0,0,0, 0,  0, 1,1,22,1,1,1,0);
    vecs[17] = mk(0,0,0,0, 0,  0, 1,0,22,1,1,0,1);
    vecs[18] = mk(1,1,0,0, 0,  1, 0,0,22,1,1,1,0);
    vecs[19] = mk(0,0,0,1, 0,  0, 0,1,11,0,0,1,0);
    vecs[20] = mk(0,0,0,0, 0,  1, 1,0,11,0,0,1,0);
    vecs[21] = mk(0,0,0,0, 0,  0, 1,1,22,0,1,1,0);
    vecs[22] = mk(0,0,0,0, 0,  1, 2,0,22,0,1,1,0);
    vecs[23] = mk(0,0,0,0, 0,  0, 2,1,33,1,0,1,0);
    vecs[24] = mk(0,0,0,0, 0,  1, 3,0,33,1,0,1,0);
    vecs[25] = mk(0,0,0,0, 0,  0, 3,1,44,1,1,1,0);
    vecs[26] = mk(0,0,0,0, 0,  1, 0,0,44,1,1,1,1);
    vecs[27] = mk(0,0,0,0, 0,  0, 0,1,11,0,0,1,0);
    vecs[28] = mk(0,0,0,0, 0,  1, 1,0,11,0,0,1,0);
    vecs[29] = mk(0,0,0,0, 0,  0, 1,1,22,0,1,1,0);
    vecs[30] = mk(0,0,1,0, 0,  0, 1,0,22,0,1,0,1);
    vecs[31] = mk(0,0,0,0, 0,  0, 1,0,22,0,1,0,0);

    for (int i = 0; i < 64; i++) mem[i] = 8'd0;
    mem[0]  = 8'd11;
    mem[1]  = 8'd22;
    mem[2]  = 8'd33;
    mem[3]  = 8'd44;
    mem[62] = 8'd66;
    mem[63] = 8'd77;

    start_a = 1'b0; loop_a = 1'b0; stop_a = 1'b0; hold_a = 1'b0; base_a = 6'd0;
    start_b = 1'b0; hold_b = 1'b0;
`ifdef MATRIX_DISPLAY_SEQ_TRANSPOSE_EN
    transpose_a = 1'b0;
    transpose_b = 1'b0;
`endif
    rst = 1'b0;
    #1 rst = 1'b1;
    #11;
    chk_zero_a("reset");
    rst = 1'b0;
    tick();

    // Per-tick table: plain pass, start during busy/done, wrap at 62,
    // loop with pass marker, hold in FETCH ignored, stop mid-pass.
    for (int i = 0; i < 32; i++) begin
      start_a = vecs[i].start;
      loop_a  = vecs[i].lp;
      stop_a  = vecs[i].sp;
      hold_a  = vecs[i].hd;
      base_a  = vecs[i].base;
      tick();
      chk($sformatf("v%0d_rd_en", i),   32'(mif_a.rd_en),   32'(vecs[i].e_rd_en));
      chk($sformatf("v%0d_rd_addr", i), 32'(mif_a.rd_addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d_vv", i),      32'(vv_a),          32'(vecs[i].e_vv));
      chk($sformatf("v%0d_value", i),   32'(value_a),       32'(vecs[i].e_val));
      chk($sformatf("v%0d_row", i),     32'(row_a),         32'(vecs[i].e_row));
      chk($sformatf("v%0d_col", i),     32'(col_a),         32'(vecs[i].e_col));
      chk($sformatf("v%0d_busy", i),    32'(busy_a),        32'(vecs[i].e_busy));
      chk($sformatf("v%0d_done", i),    32'(done_a),        32'(vecs[i].e_done));
    end
    start_a = 1'b0; loop_a = 1'b0; stop_a = 1'b0; hold_a = 1'b0; base_a = 6'd0;

    // DWELL=3: capture to next strobe is 3 ticks, stretched by a 5-tick hold.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    wait_vv(1'b1, 8'd11, "b_elem0_vv");
    count_rd_b(n);
    chk("b_dwell_no_hold", 32'(n), 32'd3);
    wait_vv(1'b1, 8'd22, "b_elem1_vv");
    hold_b = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (mif_b.rd_en || value_b != 8'd22 || !busy_b) bad = 1'b1;
    end
    chk("b_hold_frozen", 32'(bad), 32'd0);
    hold_b = 1'b0;
    count_rd_b(n);
    chk("b_hold_delay", 32'(5 + n), 32'd8);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (done_b) found = 1'b1;
    end
    chk("b_pass_done", 32'(found), 32'd1);
    chk("b_idle_busy", 32'(busy_b), 32'd0);

    // Hold and stop together in loop mode: hold wins until released.
    loop_a  = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    loop_a  = 1'b0;
    wait_vv(1'b0, 8'd22, "a_loop_elem1");
    hold_a = 1'b1;
    stop_a = 1'b1;
    bad = 1'b0;
    repeat (3) begin
      tick();
      if (!busy_a || done_a || mif_a.rd_en) bad = 1'b1;
    end
    chk("hold_over_stop", 32'(bad), 32'd0);
    hold_a = 1'b0;
    tick();
    chk("stop_done", 32'(done_a), 32'd1);
    chk("stop_busy", 32'(busy_a), 32'd0);
    stop_a = 1'b0;
    tick();
    chk("stop_done_pulse", 32'(done_a), 32'd0);

`ifdef MATRIX_DISPLAY_SEQ_TRANSPOSE_EN
    // Column-major traversal reports true coordinates.
    tv = '{8'd11, 8'd33, 8'd22, 8'd44};
    tr = '{1'b0, 1'b1, 1'b0, 1'b1};
    tc = '{1'b0, 1'b0, 1'b1, 1'b1};
    transpose_a = 1'b1;
    start_a     = 1'b1;
    tick();
    start_a     = 1'b0;
    transpose_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
        tick();
        if (vv_a) found = 1'b1;
      end
      chk($sformatf("trn%0d_seen", k),  32'(found),   32'd1);
      chk($sformatf("trn%0d_value", k), 32'(value_a), 32'(tv[k]));
      chk($sformatf("trn%0d_row", k),   32'(row_a),   32'(tr[k]));
      chk($sformatf("trn%0d_col", k),   32'(col_a),   32'(tc[k]));
    end
    tick();
    chk("trn_done", 32'(done_a), 32'd1);
    tick();
`endif

    // Asynchronous reset while showing element 2 aborts with no done pulse.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_vv(1'b0, 8'd33, "a_pre_rst_elem2");
    #2 rst = 1'b1;
    #1;
    chk_zero_a("rst_async");
    bad = 1'b0;
    repeat (2) begin
      tick();
      if (done_a || busy_a) bad = 1'b1;
    end
    chk("rst_no_done", 32'(bad), 32'd0);
    #3 rst = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("rst_restart_rd_en", 32'(mif_a.rd_en),   32'd1);
    chk("rst_restart_addr",  32'(mif_a.rd_addr), 32'd0);
    chk("rst_restart_busy",  32'(busy_a),        32'd1);
    tick();
    chk("rst_restart_vv",    32'(vv_a),    32'd1);
    chk("rst_restart_value", 32'(value_a), 32'd11);
    chk("rst_restart_row",   32'(row_a),   32'd0);
    chk("rst_restart_col",   32'(col_a),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
